alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//   Parametrised, handshaked successor to the single-cycle ALU.
//   - Operands enter on a valid/ready input port; results leave through a registered valid/ready output port.
//   - Single-cycle ops sustain one result per clock.
//   - Adds shifts and an iterative shift-add multiplier (MUL).
//   - Sits between the operand-fetch stage and the writeback stage.
// PARAMETERS
//   WIDTH       32  datapath width; power of 2, >= 4
//   ENABLE_MUL  1   1: op 3 is MUL; 0: op 3 is illegal
//   SHW         $clog2(WIDTH)  localparam; shift-amount width
// PORTS
//   clk          in   1      clock, all logic on rising edge
//   rst          in   1      synchronous reset, active-high
//   in_valid     in   1      src1/src2/alu_control valid
//   in_ready     out  1      block can accept this cycle
//   src1         in   WIDTH  operand A
//   src2         in   WIDTH  operand B; shifts use src2[SHW-1:0]
//   alu_control  in   4      0 AND, 1 OR, 2 ADD, 3 MUL, 6 SUB, 7 SLT, 8 SLL, 9 SRL, 10 SRA, 12 NOR
//   out_valid    out  1      result/flags valid
//   out_ready    in   1      consumer takes result this cycle
//   result       out  WIDTH  registered result
//   zero         out  1      result == 0
//   cout         out  1      carry out (ADD/SUB/SLT only)
//   overflow     out  1      signed overflow (ADD/SUB/SLT only)
//   illegal      out  1      result came from an undefined opcode
//   busy         out  1      MUL in progress
// BEHAVIOUR
//   Reset (rst=1 at an edge):
//   - All outputs 0; state=IDLE; a MUL in flight is abandoned with no output.
//   Handshakes:
//   - accept = in_valid & in_ready.
//   - in_ready = (state==IDLE) & (~out_valid | out_ready).
//   - Output transfer = out_valid & out_ready.
//   - While out_valid=1 and out_ready=0, result and all flags hold stable.
//   FSM IDLE:
//   - Accept of a non-MUL op: result registered at that edge; out_valid=1 next cycle (latency 1).
//   - Back-to-back accepts allowed while out_ready=1.
//   - Transfer with no new accept: out_valid->0.
//   - Accept of MUL: latch operands; cnt=0, acc=0; go to MUL; busy=1.
//   - An output transfer in the same cycle clears out_valid.
//   FSM MUL:
//   - Each cycle: if B[0], acc+=A; A<<=1; B>>=1; cnt++.
//   - When cnt==WIDTH-1 at an edge: go to IDLE, result=acc (low WIDTH bits), out_valid=1, busy=0.
//   - out_valid rises exactly WIDTH cycles after the accept edge.
//   - in_ready=0 throughout MUL.
//   Arithmetic (WIDTH-bit, two's complement):
//   - ADD: {cout,result} = src1 + src2.
//   - SUB: {cout,result} = src1 + ~src2 + 1; cout=1 means no borrow.
//   - overflow = operands' effective signs equal and result sign differs.
//   - SLT: result = {0..,diff[W-1]^ovf}; cout/overflow taken from the SUB.
//   - SLL/SRL/SRA: shift src1 by src2[SHW-1:0]; SRA sign-fills.
//   - AND/OR/NOR/MUL/shifts: cout=0, overflow=0.
//   - zero = (result==0) for every op, including SLT.
//   - Undefined opcode (incl. 3 with ENABLE_MUL=0): result=0, zero=1, cout=0, overflow=0, illegal=1, latency 1.
//   - illegal=0 for all defined ops.
// TESTING (WIDTH=32 unless noted)
//   - ADD 7FFFFFFF+00000001 -> result 80000000, zero/cout/ovf = 0/0/1; out_valid one cycle after accept.
//   - SUB 00000005-00000005 -> 00000000, z/c/v=1/1/0. SLT FFFFFFFF,00000001 -> 00000001, z/c/v=0/1/0.
//   - MUL 00010000*00010000 -> 00000000, zero=1; MUL 0000FFFF*0000FFFF -> FFFE0001.
//     For both: in_ready=0 and busy=1 for 32 cycles; out_valid at accept+32.
//   - Backpressure: 3 back-to-back ADDs with out_ready=0 after the first result.
//     -> Only one accept until released; result holds; no loss or duplication when out_ready returns.
//   - SRA 80000000 by 4 -> F8000000. SLL 1 by 31 -> 80000000. Opcode 5 -> 0, illegal=1, zero=1.
//   - rst=1 mid-MUL at cycle 10 -> next cycle all outputs 0, in_ready=1; a new ADD completes normally.

Source files
------------

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Handshaked ALU. Operands enter through a valid/ready input
//                port; results and flags leave through a registered
//                valid/ready output port. Single-cycle ops have latency 1 and
//                can issue every clock. MUL is an iterative shift-add
//                multiplier that takes WIDTH cycles.
//  Ports       : clk, rst             - clock, synchronous active-high reset
//                in_valid / in_ready  - operand handshake
//                src1, src2           - operands (shifts use src2[SHW-1:0])
//                alu_control          - 0 AND, 1 OR, 2 ADD, 3 MUL, 6 SUB,
//                                       7 SLT, 8 SLL, 9 SRL, 10 SRA, 12 NOR
//                out_valid / out_ready- result handshake
//                result, zero, cout,
//                overflow, illegal    - registered result and flags
//                busy                 - MUL in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int WIDTH      = 32,
    parameter bit ENABLE_MUL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             illegal,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_MUL  = 1'b1;

    localparam logic [3:0] c_OP_AND = 4'd0;
    localparam logic [3:0] c_OP_OR  = 4'd1;
    localparam logic [3:0] c_OP_ADD = 4'd2;
    localparam logic [3:0] c_OP_MUL = 4'd3;
    localparam logic [3:0] c_OP_SUB = 4'd6;
    localparam logic [3:0] c_OP_SLT = 4'd7;
    localparam logic [3:0] c_OP_SLL = 4'd8;
    localparam logic [3:0] c_OP_SRL = 4'd9;
    localparam logic [3:0] c_OP_SRA = 4'd10;
    localparam logic [3:0] c_OP_NOR = 4'd12;

    localparam logic [SHW-1:0] c_CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] c_CNT_ONE  = SHW'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]       r_state_q,     w_state_d;
    logic             r_out_valid_q, w_out_valid_d;
    logic [WIDTH-1:0] r_result_q,    w_result_d;
    logic             r_zero_q,      w_zero_d;
    logic             r_cout_q,      w_cout_d;
    logic             r_ovf_q,       w_ovf_d;
    logic             r_illegal_q,   w_illegal_d;
    logic [WIDTH-1:0] r_mul_a_q,     w_mul_a_d;
    logic [WIDTH-1:0] r_mul_b_q,     w_mul_b_d;
    logic [WIDTH-1:0] r_acc_q,       w_acc_d;
    logic [SHW-1:0]   r_cnt_q,       w_cnt_d;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_cout;
    logic             w_alu_ovf;
    logic             w_alu_ill;
    logic             w_is_mul;

    always_comb begin
        w_sum   = {1'b0, src1} + {1'b0, src2};
        // Carry out of src1 + ~src2 + 1 is set when no borrow occurs.
        w_diff  = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};
        // Effective sign of the second operand is inverted for subtraction.
        w_add_ovf = (src1[WIDTH-1] == src2[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != src1[WIDTH-1]);
        w_sub_ovf = (src1[WIDTH-1] != src2[WIDTH-1]) &&
                    (w_diff[WIDTH-1] != src1[WIDTH-1]);
        w_shamt = src2[SHW-1:0];

        w_alu_res  = '0;
        w_alu_cout = 1'b0;
        w_alu_ovf  = 1'b0;
        w_alu_ill  = 1'b0;
        w_is_mul   = 1'b0;

        case (alu_control)
            c_OP_AND: w_alu_res = src1 & src2;
            c_OP_OR:  w_alu_res = src1 | src2;
            c_OP_NOR: w_alu_res = ~(src1 | src2);
            c_OP_ADD: begin
                w_alu_res  = w_sum[WIDTH-1:0];
                w_alu_cout = w_sum[WIDTH];
                w_alu_ovf  = w_add_ovf;
            end
            c_OP_SUB: begin
                w_alu_res  = w_diff[WIDTH-1:0];
                w_alu_cout = w_diff[WIDTH];
                w_alu_ovf  = w_sub_ovf;
            end
            c_OP_SLT: begin
                // True signed less-than: difference sign corrected by overflow.
                w_alu_res  = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_sub_ovf};
                w_alu_cout = w_diff[WIDTH];
                w_alu_ovf  = w_sub_ovf;
            end
            c_OP_SLL: w_alu_res = src1 << w_shamt;
            c_OP_SRL: w_alu_res = src1 >> w_shamt;
            c_OP_SRA: w_alu_res = $unsigned($signed(src1) >>> w_shamt);
            c_OP_MUL: begin
                if (ENABLE_MUL) begin
                    w_is_mul = 1'b1;
                end else begin
                    w_alu_ill = 1'b1;
                end
            end
            default:  w_alu_ill = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and control
    // ------------------------------------------------------------------
    logic             w_accept;
    logic             w_xfer;
    logic [WIDTH-1:0] w_mul_step;

    assign in_ready = (r_state_q == c_ST_IDLE) & (~r_out_valid_q | out_ready);
    assign w_accept = in_valid & in_ready;
    assign w_xfer   = r_out_valid_q & out_ready;

    // One partial-product step; on the last count this already includes
    // the final multiplier bit, so WIDTH steps cover every bit of B.
    assign w_mul_step = r_mul_b_q[0] ? (r_acc_q + r_mul_a_q) : r_acc_q;

    always_comb begin
        w_state_d     = r_state_q;
        w_out_valid_d = r_out_valid_q;
        w_result_d    = r_result_q;
        w_zero_d      = r_zero_q;
        w_cout_d      = r_cout_q;
        w_ovf_d       = r_ovf_q;
        w_illegal_d   = r_illegal_q;
        w_mul_a_d     = r_mul_a_q;
        w_mul_b_d     = r_mul_b_q;
        w_acc_d       = r_acc_q;
        w_cnt_d       = r_cnt_q;

        case (r_state_q)
            c_ST_IDLE: begin
                if (w_xfer) begin
                    w_out_valid_d = 1'b0;
                end
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_mul_a_d = src1;
                        w_mul_b_d = src2;
                        w_acc_d   = '0;
                        w_cnt_d   = '0;
                        w_state_d = c_ST_MUL;
                    end else begin
                        w_result_d    = w_alu_res;
                        w_zero_d      = (w_alu_res == '0);
                        w_cout_d      = w_alu_cout;
                        w_ovf_d       = w_alu_ovf;
                        w_illegal_d   = w_alu_ill;
                        w_out_valid_d = 1'b1;
                    end
                end
            end
            c_ST_MUL: begin
                w_acc_d   = w_mul_step;
                w_mul_a_d = r_mul_a_q << 1;
                w_mul_b_d = r_mul_b_q >> 1;
                w_cnt_d   = r_cnt_q + c_CNT_ONE;
                if (r_cnt_q == c_CNT_LAST) begin
                    w_state_d     = c_ST_IDLE;
                    w_result_d    = w_mul_step;
                    w_zero_d      = (w_mul_step == '0);
                    w_cout_d      = 1'b0;
                    w_ovf_d       = 1'b0;
                    w_illegal_d   = 1'b0;
                    w_out_valid_d = 1'b1;
                end
            end
            default: w_state_d = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= c_ST_IDLE;
            r_out_valid_q <= 1'b0;
            r_result_q    <= '0;
            r_zero_q      <= 1'b0;
            r_cout_q      <= 1'b0;
            r_ovf_q       <= 1'b0;
            r_illegal_q   <= 1'b0;
            r_mul_a_q     <= '0;
            r_mul_b_q     <= '0;
            r_acc_q       <= '0;
            r_cnt_q       <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_out_valid_q <= w_out_valid_d;
            r_result_q    <= w_result_d;
            r_zero_q      <= w_zero_d;
            r_cout_q      <= w_cout_d;
            r_ovf_q       <= w_ovf_d;
            r_illegal_q   <= w_illegal_d;
            r_mul_a_q     <= w_mul_a_d;
            r_mul_b_q     <= w_mul_b_d;
            r_acc_q       <= w_acc_d;
            r_cnt_q       <= w_cnt_d;
        end
    end

    assign out_valid = r_out_valid_q;
    assign result    = r_result_q;
    assign zero      = r_zero_q;
    assign cout      = r_cout_q;
    assign overflow  = r_ovf_q;
    assign illegal   = r_illegal_q;
    assign busy      = (r_state_q == c_ST_MUL);

endmodule
`default_nettype wire
